// File: rtl/ir_rx_decoder.sv
// IR receive decoder: times marks/spaces of the demodulated envelope and decodes
// one frame (lead, 35-bit word, connect code, 32-bit word) into data35/data32.
module ir_rx_decoder #(
  parameter int unsigned LEAD_MARK_MIN  = 800000,
  parameter int unsigned LEAD_MARK_MAX  = 1000000,
  parameter int unsigned LEAD_SPACE_MIN = 400000,
  parameter int unsigned LEAD_SPACE_MAX = 500000,
  parameter int unsigned ZERO_MARK_MIN  = 50000,
  parameter int unsigned ZERO_MARK_MAX  = 100000,
  parameter int unsigned ONE_MARK_MIN   = 120000,
  parameter int unsigned ONE_MARK_MAX   = 180000,
  parameter int unsigned BIT_SPACE_MIN  = 30000,
  parameter int unsigned BIT_SPACE_MAX  = 100000,
  parameter int unsigned CONN_SPACE_MIN = 1800000,
  parameter int unsigned CONN_SPACE_MAX = 2100000,
  parameter int unsigned TIMEOUT        = 2500000,
  parameter int          LEN_W          = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  output logic [34:0] data35,
  output logic [31:0] data32,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_D35_MARK, S_D35_SPACE, S_CONN_WAIT,
    S_CONN_MARK, S_CONN_SPACE, S_D32_MARK, S_D32_SPACE, S_ERR
  } state_t;

  state_t            r_state;
  logic              r_sync1, r_ir_s, r_ir_d;
  logic [LEN_W-1:0]  r_len;
  logic [5:0]        r_cnt;
  logic [34:0]       r_sr35;
  logic [30:0]       r_sr32;
  logic [34:0]       r_data35;
  logic [31:0]       r_data32;
  logic              r_frame_valid, r_frame_err;

  logic              w_rise, w_fall;
  logic [31:0]       w_len32;
  logic              w_is0, w_is1, w_bit_ok;
  logic              w_timeout;

  function automatic logic in_win(input logic [31:0] v, input logic [31:0] lo,
                                  input logic [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  assign w_rise    = r_ir_s & ~r_ir_d;
  assign w_fall    = ~r_ir_s & r_ir_d;
  assign w_len32   = 32'(r_len);
  assign w_is0     = in_win(w_len32, ZERO_MARK_MIN, ZERO_MARK_MAX);
  assign w_is1     = in_win(w_len32, ONE_MARK_MIN, ONE_MARK_MAX);
  assign w_bit_ok  = w_is0 | w_is1;
  assign w_timeout = (r_state != S_IDLE) && (r_state != S_ERR) && (w_len32 > TIMEOUT);

  // Synchroniser, edge delay and saturating run-length counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_ir_s  <= 1'b0;
      r_ir_d  <= 1'b0;
      r_len   <= '0;
    end else begin
      r_sync1 <= ir_in;
      r_ir_s  <= r_sync1;
      r_ir_d  <= r_ir_s;
      if (w_rise | w_fall)
        r_len <= LEN_W'(1);
      else if (r_len != '1)
        r_len <= r_len + LEN_W'(1);
    end
  end

  // Frame FSM; the old r_len is the width of the level that just ended
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_sr35        <= '0;
      r_sr32        <= '0;
      r_data35      <= '0;
      r_data32      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (w_timeout) begin
        r_state <= S_ERR;
      end else begin
        unique case (r_state)
          S_IDLE: if (w_rise) begin
            r_state <= S_LEAD_MARK;
            r_cnt   <= '0;
          end
          S_LEAD_MARK: if (w_fall)
            r_state <= in_win(w_len32, LEAD_MARK_MIN, LEAD_MARK_MAX) ? S_LEAD_SPACE : S_ERR;
          S_LEAD_SPACE: if (w_rise)
            r_state <= in_win(w_len32, LEAD_SPACE_MIN, LEAD_SPACE_MAX) ? S_D35_MARK : S_ERR;
          S_D35_MARK: if (w_fall) begin
            if (w_bit_ok) begin
              r_sr35  <= {r_sr35[33:0], w_is1};
              r_cnt   <= r_cnt + 6'd1;
              r_state <= (r_cnt == 6'd34) ? S_CONN_WAIT : S_D35_SPACE;
            end else begin
              r_state <= S_ERR;
            end
          end
          S_D35_SPACE: if (w_rise)
            r_state <= in_win(w_len32, BIT_SPACE_MIN, BIT_SPACE_MAX) ? S_D35_MARK : S_ERR;
          S_CONN_WAIT: if (w_rise)
            r_state <= in_win(w_len32, BIT_SPACE_MIN, BIT_SPACE_MAX) ? S_CONN_MARK : S_ERR;
          S_CONN_MARK: if (w_fall) begin
            r_cnt   <= '0;
            r_state <= w_is0 ? S_CONN_SPACE : S_ERR;
          end
          S_CONN_SPACE: if (w_rise)
            r_state <= in_win(w_len32, CONN_SPACE_MIN, CONN_SPACE_MAX) ? S_D32_MARK : S_ERR;
          S_D32_MARK: if (w_fall) begin
            if (!w_bit_ok) begin
              r_state <= S_ERR;
            end else if (r_cnt == 6'd31) begin
              r_data35      <= r_sr35;
              r_data32      <= {r_sr32, w_is1};
              r_frame_valid <= 1'b1;
              r_cnt         <= '0;
              r_state       <= S_IDLE;
            end else begin
              r_sr32  <= {r_sr32[29:0], w_is1};
              r_cnt   <= r_cnt + 6'd1;
              r_state <= S_D32_SPACE;
            end
          end
          S_D32_SPACE: if (w_rise)
            r_state <= in_win(w_len32, BIT_SPACE_MIN, BIT_SPACE_MAX) ? S_D32_MARK : S_ERR;
          S_ERR: begin
            r_frame_err <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign data35      = r_data35;
  assign data32      = r_data32;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ir_rx_decoder.sv
// Scoreboard bench for ir_rx_decoder with timing windows scaled down 5000x
// (1 cycle = 50 us of real frame time) so whole frames fit in a short run.
module tb_ir_rx_decoder;

  localparam logic [34:0] D35  = 35'b10000010000100000000010000001010010;
  localparam logic [31:0] D32  = 32'h08040006;
  localparam logic [34:0] D35B = 35'h5_A5C3_0F1E;
  localparam logic [31:0] D32B = 32'hC3A5_0FF1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_in;
  logic [34:0] data35;
  logic [31:0] data32;
  logic        frame_valid, frame_err, busy;

  ir_rx_decoder #(
    .LEAD_MARK_MIN(160), .LEAD_MARK_MAX(200),
    .LEAD_SPACE_MIN(80), .LEAD_SPACE_MAX(100),
    .ZERO_MARK_MIN(10),  .ZERO_MARK_MAX(20),
    .ONE_MARK_MIN(24),   .ONE_MARK_MAX(36),
    .BIT_SPACE_MIN(6),   .BIT_SPACE_MAX(20),
    .CONN_SPACE_MIN(360), .CONN_SPACE_MAX(420),
    .TIMEOUT(500), .LEN_W(22)
  ) dut (
    .clk(clk), .rst(rst), .ir_in(ir_in),
    .data35(data35), .data32(data32),
    .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [34:0] d35;
    logic [31:0] d32;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   valid_cyc = -1;
  int   fall_cyc = -1;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic push_exp(input logic is_err, input logic [34:0] d35, input logic [31:0] d32);
    exp_t e;
    e.is_err = is_err;
    e.d35    = d35;
    e.d32    = d32;
    q.push_back(e);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (!rst && (frame_valid || frame_err)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {62'd0, frame_valid, frame_err}, 64'd0);
      end else begin
        e_mon = q.pop_front();
        chk("pulse_kind", {62'd0, frame_valid, frame_err},
            e_mon.is_err ? 64'd1 : 64'd2);
        if (!e_mon.is_err) begin
          valid_cyc = cyc;
          chk("data35", 64'(data35), 64'(e_mon.d35));
          chk("data32", 64'(data32), 64'(e_mon.d32));
        end
      end
    end
  end

  function automatic int sc(input int nom, input int pct);
    return (nom * pct + 50) / 100;
  endfunction

  task automatic lvl(input logic v, input int n);
    ir_in = v;
    repeat (n) @(negedge clk);
  endtask

  // One frame; lm=0 uses the scaled lead mark. Negative indices disable the fault hooks.
  task automatic send_frame(input logic [34:0] d35, input logic [31:0] d32,
                            input int pct, input int cpct, input int lm_in,
                            input int bad_bit, input int stuck_after, input int abort32);
    int zm, om, zs, os, cm, cs, ls, lm;
    logic b;
    zm = sc(15, pct);  om = sc(30, pct);
    zs = sc(9, pct);   os = sc(15, pct);
    cm = sc(15, pct);  cs = sc(385, cpct);
    ls = sc(90, pct);
    lm = (lm_in == 0) ? sc(180, pct) : lm_in;
    lvl(1'b1, lm);
    if (lm < 160 || lm > 200) begin
      lvl(1'b0, 40);
      return;
    end
    lvl(1'b0, ls);
    for (int i = 0; i < 35; i++) begin
      b = d35[34-i];
      if (i == stuck_after) begin
        lvl(1'b1, 1500);
        lvl(1'b0, 40);
        return;
      end
      if (i == bad_bit) begin
        lvl(1'b1, 22);
        lvl(1'b0, 40);
        return;
      end
      lvl(1'b1, b ? om : zm);
      lvl(1'b0, b ? os : zs);
    end
    lvl(1'b1, cm);
    lvl(1'b0, cs);
    for (int i = 0; i < 32; i++) begin
      b = d32[31-i];
      if (i == abort32) begin
        lvl(1'b1, 10);
        return;
      end
      if (i == 31) begin
        lvl(1'b1, b ? om : zm);
        ir_in    = 1'b0;
        fall_cyc = cyc;
        repeat (40) @(negedge clk);
      end else begin
        lvl(1'b1, b ? om : zm);
        lvl(1'b0, b ? os : zs);
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    ir_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data35", 64'(data35), 64'd0);
    chk("reset_data32", 64'(data32), 64'd0);
    chk("reset_valid", 64'(frame_valid), 64'd0);
    chk("reset_err", 64'(frame_err), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Nominal frame
    push_exp(1'b0, D35, D32);
    send_frame(D35, D32, 100, 100, 0, -1, -1, -1);
    wait_drain();
    chk("idle_after_frame_busy", 64'(busy), 64'd0);

    // Stretched and shrunk timing; the connect space window is tighter than 10%
    push_exp(1'b0, D35, D32);
    send_frame(D35, D32, 110, 104, 0, -1, -1, -1);
    wait_drain();
    push_exp(1'b0, D35, D32);
    send_frame(D35, D32, 90, 96, 0, -1, -1, -1);
    wait_drain();

    // Short lead mark, then recovery
    push_exp(1'b1, '0, '0);
    send_frame(D35, D32, 100, 100, 140, -1, -1, -1);
    wait_drain();
    push_exp(1'b0, D35, D32);
    send_frame(D35, D32, 100, 100, 0, -1, -1, -1);
    wait_drain();

    // 1.1 ms mark on data35[20] (received bit 14)
    push_exp(1'b1, '0, '0);
    send_frame(D35, D32, 100, 100, 0, 14, -1, -1);
    wait_drain();
    chk("hold_data35_after_bad_bit", 64'(data35), 64'(D35));
    chk("hold_data32_after_bad_bit", 64'(data32), 64'(D32));

    // Stuck mark after 10 data bits
    push_exp(1'b1, '0, '0);
    send_frame(D35, D32, 100, 100, 0, -1, 10, -1);
    wait_drain();
    chk("busy_after_timeout", 64'(busy), 64'd0);
    chk("hold_data35_after_timeout", 64'(data35), 64'(D35));

    // Reset in the middle of the 32-bit word
    send_frame(D35, D32, 100, 100, 0, -1, -1, 5);
    chk("busy_in_d32", 64'(busy), 64'd1);
    rst   = 1'b1;
    ir_in = 1'b0;
    @(negedge clk);
    chk("midreset_data35", 64'(data35), 64'd0);
    chk("midreset_data32", 64'(data32), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    push_exp(1'b0, D35B, D32B);
    send_frame(D35B, D32B, 100, 100, 0, -1, -1, -1);
    wait_drain();
    chk("fall_to_valid_latency", 64'(valid_cyc - fall_cyc), 64'd3);

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
